// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is willing to take a byte from the source.
    function automatic logic is_rx_state(input state_e s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; the word is presented
// combinationally in the same cycle its last byte arrives.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        in_vld,
    input  logic [7:0]  in_dat,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      sr_q;

    // Shift right so the first byte of a word ends up in the low lane.
    assign word       = {in_dat, sr_q[31:8]};
    assign word_valid = in_vld && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (in_vld) begin
            cnt_q <= cnt_q + 1'b1;
            sr_q  <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte frame and writes it into
// instruction memory, holding the core until the image is complete and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int               LEN_W     = HDR_BYTES * 8;
    localparam int               GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W:0]   MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

    state_e              state_q;
    logic [7:0]          len_lo_q;
    logic [ADDR_W:0]     len_q;
    logic [7:0]          xor_q;
    logic [GAP_W-1:0]    gap_q;
    logic [ADDR_W:0]     words_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_hold_q;
    logic                done_q;
    logic                err_q;

    logic                xfer;
    logic [LEN_W-1:0]    len_d;
    logic                len_over;
    logic [ADDR_W:0]     words_d;
    logic                last_word;
    logic                gap_state;
    logic                gap_expire;
    logic                word_valid;
    logic [31:0]         word;

    assign rx_ready   = is_rx_state(state_q) && !reload;
    assign xfer       = rx_valid && rx_ready;
    assign len_d      = {rx_data, len_lo_q};
    assign len_over   = {1'b0, len_d} > MAX_WORDS;
    assign words_d    = words_q + 1'b1;
    assign last_word  = (words_d == len_q);
    assign gap_state  = (state_q == S_LEN1) || (state_q == S_DATA) || (state_q == S_CSUM);
    // Expire on the idle cycle that would bring the counter up to TIMEOUT.
    assign gap_expire = gap_state && !xfer && (gap_q == GAP_W'(TIMEOUT - 1));

    imem_word_packer u_packer (
        .clk        (clk),
        .clr        (rst || reload),
        .in_vld     (xfer && (state_q == S_DATA)),
        .in_dat     (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN0;
            len_lo_q     <= '0;
            len_q        <= '0;
            xor_q        <= '0;
            gap_q        <= '0;
            words_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (reload) begin
            // Previously written words and the last address/data stay put.
            state_q     <= S_LEN0;
            xor_q       <= '0;
            gap_q       <= '0;
            words_q     <= '0;
            imem_we_q   <= 1'b0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;

            if (xfer) begin
                gap_q <= '0;
            end else if (gap_state) begin
                gap_q <= gap_q + 1'b1;
            end

            if (xfer && (state_q != S_CSUM)) begin
                xor_q <= xor_q ^ rx_data;
            end

            if (word_valid) begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= words_q[ADDR_W-1:0];
                imem_wdata_q <= word;
                words_q      <= words_d;
            end

            case (state_q)
                S_LEN0: begin
                    if (xfer) begin
                        len_lo_q <= rx_data;
                        state_q  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len_q <= (ADDR_W + 1)'(len_d);
                        if (len_over) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (len_d == '0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid && last_word) begin
                        state_q <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (rx_data == xor_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (gap_expire) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
            end
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_hold    = core_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
